dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one request/ack data bus between the pipeline memory
// stage and the cache-op port, with optional fair arbitration and an ack timeout.
module dmem_arbiter #(
    parameter int FAIR_EN     = 1,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic        flush,
    output logic        stall,
    input  logic        cop_req,
    input  logic [31:0] cop_addr,
    input  logic [1:0]  cop_type,
    output logic        cop_done,
    output logic        bus_req,
    output logic        bus_wr,
    output logic        bus_cop,
    output logic [1:0]  bus_type,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PIPE_BUSY = 3'd1;
    localparam logic [2:0] COP_BUSY  = 3'd2;
    localparam logic [2:0] PIPE_RESP = 3'd3;
    localparam logic [2:0] COP_RESP  = 3'd4;

    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = (ACK_TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(ACK_TIMEOUT - 1);

    logic [2:0]       state_r;
    logic             last_cop_r;
    logic             owned_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pipe_req_s;
    logic             grant_pipe_s;
    logic             grant_cop_s;
    logic             timeout_s;

    // Arbitration: grants only from IDLE; a tie goes to the port not served last when fair.
    always_comb begin
        pipe_req_s   = mem_en & ~flush;
        grant_pipe_s = 1'b0;
        grant_cop_s  = 1'b0;
        if (state_r == IDLE) begin
            if (pipe_req_s && cop_req) begin
                if ((FAIR_EN != 0) && last_cop_r) begin
                    grant_pipe_s = 1'b1;
                end else begin
                    grant_cop_s = 1'b1;
                end
            end else begin
                grant_pipe_s = pipe_req_s;
                grant_cop_s  = cop_req;
            end
        end else begin
            grant_pipe_s = 1'b0;
            grant_cop_s  = 1'b0;
        end
    end

    // Timeout fires on the ACK_TIMEOUT-th BUSY cycle that sees no ack.
    always_comb begin
        timeout_s = 1'b0;
        if ((ACK_TIMEOUT != 0) && (cnt_r == TMO_LAST) && !bus_ack) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // A flushed pipeline access no longer owns the response, so stall cannot release on it.
    assign stall = mem_en & ~flush & ~((state_r == PIPE_RESP) & owned_r);

    // Transaction FSM, registered bus request and load-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            last_cop_r <= 1'b0;
            owned_r    <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_cop    <= 1'b0;
            bus_type   <= 2'b00;
            bus_wstrb  <= 4'b0000;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_err    <= 1'b0;
            cop_done   <= 1'b0;
            mem_rdata  <= 32'h0;
        end else begin
            bus_err  <= 1'b0;
            cop_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_cop_s) begin
                        bus_req    <= 1'b1;
                        bus_wr     <= 1'b0;
                        bus_cop    <= 1'b1;
                        bus_type   <= cop_type;
                        bus_wstrb  <= 4'b0000;
                        bus_addr   <= cop_addr;
                        bus_wdata  <= 32'h0;
                        cnt_r      <= {CNT_W{1'b0}};
                        last_cop_r <= 1'b1;
                        state_r    <= COP_BUSY;
                    end else if (grant_pipe_s) begin
                        bus_req    <= 1'b1;
                        bus_wr     <= |mem_wen;
                        bus_cop    <= 1'b0;
                        bus_type   <= 2'b00;
                        bus_wstrb  <= mem_wen;
                        bus_addr   <= mem_addr;
                        bus_wdata  <= mem_wdata;
                        cnt_r      <= {CNT_W{1'b0}};
                        last_cop_r <= 1'b0;
                        owned_r    <= 1'b1;
                        state_r    <= PIPE_BUSY;
                    end
                end
                PIPE_BUSY: begin
                    if (flush) begin
                        owned_r <= 1'b0;
                    end
                    if (bus_ack || timeout_s) begin
                        if (owned_r && !flush) begin
                            mem_rdata <= bus_ack ? bus_rdata : 32'h0;
                        end
                        bus_req <= 1'b0;
                        bus_err <= ~bus_ack;
                        state_r <= PIPE_RESP;
                    end
                    if (!bus_ack && (ACK_TIMEOUT != 0)) begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end
                COP_BUSY: begin
                    if (bus_ack || timeout_s) begin
                        bus_req  <= 1'b0;
                        bus_err  <= ~bus_ack;
                        cop_done <= 1'b1;
                        state_r  <= COP_RESP;
                    end
                    if (!bus_ack && (ACK_TIMEOUT != 0)) begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end
                PIPE_RESP, COP_RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule
